// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin grant arbiter; optional forced release via RR_GRANT_ARBITER_TIMEOUT_EN
module rr_grant_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_valid,
  output logic                       timeout
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    win_next;
  logic               own_req;
  logic               own_done;
  logic               rel;

`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic               hold_max;

  assign hold_max = (hold_q == HOLD_W'(MAX_HOLD));
`endif

  // Only the current owner's req/done bits matter while OWNED
  assign own_req  = req[grant_id_q];
  assign own_done = done[grant_id_q];

  // Round-robin scan starting at ptr, wrapping modulo NUM_REQ; first set req wins
  always_comb begin
    logic [ID_W:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req[sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[ID_W-1:0];
      end
    end
  end

  // Pointer value after granting win_idx: the index just past the winner
  always_comb begin
    logic [ID_W:0] nxt;
    nxt = {1'b0, win_idx} + (ID_W+1)'(1);
    if (nxt >= (ID_W+1)'(NUM_REQ)) begin
      nxt = '0;
    end
    win_next = nxt[ID_W-1:0];
  end

  // FSM next state and next registered outputs
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    rel           = 1'b0;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
    hold_d        = hold_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = OWNED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_id_d       = win_idx;
          grant_valid_d    = 1'b1;
          ptr_d            = win_next;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
          hold_d           = HOLD_W'(1);
`endif
        end
      end
      OWNED: begin
        rel = own_done || !own_req;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
        // A voluntary release in the same cycle wins over the forced one
        if (!rel && hold_max) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else if (!rel) begin
          // Forced release fires at MAX_HOLD, so the count never passes it
          hold_d    = hold_q + HOLD_W'(1);
        end
`endif
        if (rel) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
          hold_d        = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
    end
  end

`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
  // Hold counter and one-cycle timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - scoreboard bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         c;
    logic [7:0] r;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prev_r = '0;

  rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every change of the output record pops one expectation
  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t       e;
    cur = {grant, grant_id, grant_valid, timeout};
    if (!rst_n) begin
      prev_r = '0;
    end else if (cur !== prev_r) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got={grant,id,valid,timeout}=%b", cyc, cur);
      end else begin
        e = sb.pop_front();
        if (e.c != cyc || e.r !== cur) begin
          failures++;
          $display("FAIL event got cyc=%0d rec=%b required cyc=%0d rec=%b", cyc, cur, e.c, e.r);
        end
      end
      prev_r = cur;
    end
  end

  function automatic void push(int c, logic [3:0] g, logic [1:0] id, logic v, logic t);
    exp_t e;
    e.c = c;
    e.r = {g, id, v, t};
    sb.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, expv);
    end
  endtask

  initial begin
    int         g;
    int         g2;
    int         order [5];
    logic [3:0] gvec  [5];
    order = '{0, 1, 2, 3, 0};
    gvec  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    g  = 0;
    g2 = 0;

    // Reset state
    repeat (3) step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // req=1010 right at reset release: index 1 wins, ptr moves to 2
    rst_n = 1'b1;
    req = 4'b1010;
    push(cyc + 1, 4'b0010, 2'd1, 1'b1, 1'b0);
    repeat (3) step();
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (2) step();
    // ptr=2 so index 3 wins this time, ptr wraps to 0
    req = 4'b1010;
    push(cyc + 1, 4'b1000, 2'd3, 1'b1, 1'b0);
    repeat (2) step();
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (2) step();

    // All requesting, each owner pulses done after 3 cycles: 0,1,2,3,0
    req = 4'b1111;
    g = cyc + 1;
    push(g, gvec[0], 2'(order[0]), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_until(g + 2);
      done = gvec[k];
      if (k == 4) req = 4'b0000;
      push(g + 3, 4'b0000, 2'd0, 1'b0, 1'b0);
      if (k < 4) push(g + 4, gvec[k+1], 2'(order[k+1]), 1'b1, 1'b0);
      step();
      done = 4'b0000;
      g = g + 4;
    end
    repeat (2) step();

    // ptr=1: index 2 wins; other req/done bits must not disturb it
    req = 4'b0100;
    g = cyc + 1;
    push(g, 4'b0100, 2'd2, 1'b1, 1'b0);
    wait_until(g);
    done = 4'b1000;
    req  = 4'b1100;
    step();
    done = 4'b0000;
    step();
    done = 4'b1011;
    step();
    done = 4'b0000;
    // Owner 2 drops req: release, one idle cycle, then index 3
    req = 4'b1000;
    push(g + 4, 4'b0000, 2'd0, 1'b0, 1'b0);
    push(g + 5, 4'b1000, 2'd3, 1'b1, 1'b0);

    // Asynchronous reset while index 3 owns
    wait_until(g + 7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_grant_id", 32'(grant_id), 32'd0);
    chk("async_rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("async_rst_timeout", 32'(timeout), 32'd0);
    chk("sb_drained_before_rst", 32'(sb.size()), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    push(cyc + 1, 4'b1000, 2'd3, 1'b1, 1'b0);
    repeat (3) step();
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (2) step();

    // req=0011 held with no done; ptr=0 so owner 0 first
    req = 4'b0011;
    g = cyc + 1;
    push(g, 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
    // 16 held cycles, timeout pulse with grant low, then owner 1
    push(g + 16, 4'b0000, 2'd0, 1'b0, 1'b1);
    push(g + 17, 4'b0010, 2'd1, 1'b1, 1'b0);
    g2 = g + 17;
    // done lands exactly when the hold count reaches 16: no timeout
    wait_until(g2 + 15);
    done = 4'b0010;
    push(g2 + 16, 4'b0000, 2'd0, 1'b0, 1'b0);
    push(g2 + 17, 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    done = 4'b0000;
`else
    // No forced release: owner 0 keeps the grant until it signals done
    wait_until(g + 39);
    done = 4'b0001;
    push(g + 40, 4'b0000, 2'd0, 1'b0, 1'b0);
    push(g + 41, 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    done = 4'b0000;
`endif
    repeat (4) step();
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (3) step();

    chk("sb_drained_at_end", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the requester count (legal range 2..32).
REQ-002 SHALL have parameter MAX_HOLD, default 16, giving the maximum grant-held cycles before a forced release (legal range >=1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, NUM_REQ, per-requester level request; bit i held high while requester i wants the resource.
REQ-006 SHALL have port done, input, NUM_REQ, per-requester one-cycle release pulse; only the bit of the current owner is honoured.
REQ-007 SHALL have port grant, output, NUM_REQ, registered one-hot grant; all zero when no owner.
REQ-008 SHALL have port grant_id, output, $clog2(NUM_REQ), registered binary index of the owner; 0 when no owner.
REQ-009 SHALL have port grant_valid, output, 1, registered; high when exactly one grant bit is set.
REQ-010 SHALL have port timeout, output, 1, registered one-cycle pulse marking a forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no owner) and OWNED (one owner).
REQ-012 In IDLE with req != 0, SHALL select a winner at cycle t; grant, grant_id and grant_valid assert at t+1, and the FSM enters OWNED.
REQ-013 Winner selection SHALL be round-robin: scan indices ptr, ptr+1, ..., wrapping modulo NUM_REQ; the first set req bit wins.
REQ-014 On each new grant to index k, ptr SHALL become (k+1) mod NUM_REQ; ptr SHALL NOT change at any other time.
REQ-015 In OWNED, the grant SHALL persist while req[owner]=1, done[owner]=0 and no forced release occurs; requests from other indices SHALL have no effect.
REQ-016 In OWNED, if done[owner]=1 or req[owner]=0 at cycle t, grant/grant_valid SHALL deassert at t+1 and the FSM returns to IDLE.
REQ-017 After any release, the earliest new grant SHALL be at t+2: one mandatory idle cycle with grant_valid=0.
REQ-018 done bits of non-owners and done in IDLE SHALL be ignored.
REQ-019 A hold counter SHALL load 1 on each new grant and increment each OWNED cycle, saturating at MAX_HOLD.
REQ-020 done[owner] and a forced release in the same cycle SHALL count as a normal release with timeout=0.
REQ-021 grant SHALL always be one-hot or zero, and grant_id SHALL always match the grant bit.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, without a clock, force: grant=0, grant_id=0, grant_valid=0, timeout=0, ptr=0, hold counter=0, FSM=IDLE.
REQ-023 Reset asserted mid-grant SHALL drop the grant asynchronously; after rst_n deasserts, the first grant follows REQ-012 with ptr=0.
REQ-024 The first rising clk edge with rst_n=1 SHALL be the first evaluation edge; rst_n deassertion is synchronised externally.

Configuration
REQ-025 Macro RR_GRANT_ARBITER_TIMEOUT_EN SHALL control the forced-release feature.
REQ-026 With RR_GRANT_ARBITER_TIMEOUT_EN defined, when the hold counter equals MAX_HOLD at cycle t with the owner still requesting and not done, the grant SHALL drop at t+1 and timeout=1 for exactly that cycle. The owner re-enters arbitration at lowest round-robin priority.
REQ-027 With RR_GRANT_ARBITER_TIMEOUT_EN undefined, the hold counter and forced release SHALL NOT be implemented. timeout SHALL remain tied to 0, and grants are released only per REQ-016.

Verification (NUM_REQ=4, MAX_HOLD=16)
REQ-028 SHALL cover reset then req=4'b1010 held, done never pulsed: grant=4'b0010, grant_id=1, grant_valid=1 one cycle after req; ptr=2.
REQ-029 SHALL cover all req=4'b1111, owner pulses done after 3 cycles each: grant order 0,1,2,3,0, with exactly one idle cycle between grants.
REQ-030 SHALL cover owner 2 dropping req while done=0: grant=0 next cycle; non-owner done[3] pulses during OWNED cause no change.
REQ-031 SHALL cover, with RR_GRANT_ARBITER_TIMEOUT_EN and req=4'b0011 held, no done: owner 0 holds 16 cycles, then timeout=1 for one cycle with grant=0, then grant_id=1. Without the macro: owner 0 holds indefinitely, timeout stays 0.
REQ-032 SHALL cover rst_n=0 pulsed mid-grant of index 3: grant=0 before the next clk edge; after release with req=4'b1000, grant_id=3 again.
REQ-033 SHALL cover done[owner] coinciding with hold count 16: release occurs with timeout=0.
